// File: rtl/servo_sequencer.sv
// Round-robin sequencer for four servo duty targets with slew-limited duty output and a period watchdog.
// Build option: define SERVO_SLEW_EN to limit each visit's duty change to STEP; otherwise LOAD jumps to target.
module servo_sequencer #(
    parameter int DUTY_MIN    = 100000,
    parameter int DUTY_MAX    = 200000,
    parameter int DUTY_CENTER = 150000,
    parameter int STEP        = 1000,
    parameter int TIMEOUT     = 2100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Enable,
    input  logic        TargetWrite,
    input  logic [1:0]  TargetNum,
    input  logic [20:0] TargetDuty,
    input  logic        FaultClear,
    input  logic        ActivePeriodFinished,
    output logic [1:0]  ServoNum,
    output logic [20:0] ActiveServoDuty,
    output logic        Busy,
    output logic        Fault
);

    localparam logic [20:0] DUTY_MIN_C    = 21'(DUTY_MIN);
    localparam logic [20:0] DUTY_MAX_C    = 21'(DUTY_MAX);
    localparam logic [20:0] DUTY_CENTER_C = 21'(DUTY_CENTER);
    localparam logic [20:0] STEP_C        = 21'(STEP);
    localparam logic [21:0] WD_LAST_C     = 22'(TIMEOUT - 1);
`ifdef SERVO_SLEW_EN
    localparam logic        SLEW_ON_C     = 1'b1;
`else
    localparam logic        SLEW_ON_C     = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t       state_r;
    state_t       state_nxt_s;
    logic [20:0]  target_r  [4];
    logic [20:0]  current_r [4];
    logic [1:0]   servo_r;
    logic [20:0]  duty_r;
    logic         busy_r;
    logic         fault_r;
    logic [21:0]  wd_r;
    logic [20:0]  load_duty_s;
    logic         advance_s;
    logic         timeout_s;

    function automatic logic [20:0] clamp_duty(input logic [20:0] duty);
        logic [20:0] res;
        if (duty < DUTY_MIN_C) begin
            res = DUTY_MIN_C;
        end else if (duty > DUTY_MAX_C) begin
            res = DUTY_MAX_C;
        end else begin
            res = duty;
        end
        return res;
    endfunction

    // Moves cur toward tgt by at most STEP and never overshoots the target.
    function automatic logic [20:0] slew_duty(input logic [20:0] cur, input logic [20:0] tgt);
        logic [20:0] res;
        if (tgt > cur) begin
            if ((tgt - cur) > STEP_C) begin
                res = cur + STEP_C;
            end else begin
                res = tgt;
            end
        end else if (tgt < cur) begin
            if ((cur - tgt) > STEP_C) begin
                res = cur - STEP_C;
            end else begin
                res = tgt;
            end
        end else begin
            res = cur;
        end
        return res;
    endfunction

    // New duty for the selected servo, applied when LOAD completes.
    always_comb begin
        load_duty_s = target_r[servo_r];
        if (SLEW_ON_C) begin
            load_duty_s = slew_duty(current_r[servo_r], target_r[servo_r]);
        end else begin
            load_duty_s = target_r[servo_r];
        end
    end

    // Next-state logic; a finish pulse takes priority over a simultaneous watchdog expiry.
    always_comb begin
        state_nxt_s = state_r;
        advance_s   = 1'b0;
        timeout_s   = 1'b0;
        unique case (state_r)
            ST_IDLE: begin
                if (Enable) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_nxt_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (ActivePeriodFinished) begin
                    advance_s = 1'b1;
                end else if (wd_r == WD_LAST_C) begin
                    advance_s = 1'b1;
                    timeout_s = 1'b1;
                end else begin
                    advance_s = 1'b0;
                end
                if (advance_s) begin
                    state_nxt_s = Enable ? ST_LOAD : ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Target and current duty storage; a write racing a LOAD of the same servo lands after it.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                target_r[i]  <= DUTY_CENTER_C;
                current_r[i] <= DUTY_CENTER_C;
            end
        end else begin
            if (TargetWrite) begin
                target_r[TargetNum] <= clamp_duty(TargetDuty);
            end
            if (state_r == ST_LOAD) begin
                current_r[servo_r] <= load_duty_s;
            end
        end
    end

    // Registered outputs and the watchdog counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            servo_r <= 2'd0;
            duty_r  <= DUTY_CENTER_C;
            busy_r  <= 1'b0;
            fault_r <= 1'b0;
            wd_r    <= 22'd0;
        end else begin
            busy_r <= (state_nxt_s != ST_IDLE);
            if (state_r == ST_LOAD) begin
                duty_r <= load_duty_s;
                wd_r   <= 22'd0;
            end else if (state_r == ST_WAIT) begin
                wd_r   <= wd_r + 22'd1;
            end
            if (advance_s) begin
                servo_r <= servo_r + 2'd1;
            end
            if (timeout_s) begin
                fault_r <= 1'b1;
            end else if (FaultClear) begin
                fault_r <= 1'b0;
            end
        end
    end

    assign ServoNum        = servo_r;
    assign ActiveServoDuty = duty_r;
    assign Busy            = busy_r;
    assign Fault           = fault_r;

endmodule

// File: doc/servo_sequencer.md
# servo_sequencer

Round-robin scheduler that owns the four servo position targets and drives the servo output multiplexer. It selects one servo at a time, presents that servo's slew-limited duty on a 21-bit bus, and advances to the next servo when the selected PWM channel reports its period finished. It sits directly upstream of the servo mux: its `ServoNum` and `ActiveServoDuty` feed the mux, and the mux's `ActivePeriodFinished` returns here. A watchdog advances past a channel that never finishes.

## Interface
Parameters:
- `DUTY_MIN`, 100000: lowest legal duty in clock counts (1 ms at 100 MHz).
- `DUTY_MAX`, 200000: highest legal duty (2 ms).
- `DUTY_CENTER`, 150000: reset duty for all servos.
- `STEP`, 1000: maximum duty change per visit to a servo (slew limit).
- `TIMEOUT`, 2100000: cycles in WAIT before the watchdog fires; 22-bit counter.

Ports:
- `clk` in 1: system clock; single clock domain.
- `reset` in 1: synchronous, active-high reset.
- `Enable` in 1: run the sequencer; sampled in IDLE and at each advance.
- `TargetWrite` in 1: one-cycle strobe; loads `TargetDuty` into target[`TargetNum`].
- `TargetNum` in 2: servo index for the write.
- `TargetDuty` in 21: requested duty in clock counts.
- `FaultClear` in 1: clears `Fault`.
- `ActivePeriodFinished` in 1: one-cycle pulse from the selected PWM channel via the mux.
- `ServoNum` out 2: currently selected servo.
- `ActiveServoDuty` out 21: registered duty for the selected servo.
- `Busy` out 1: high when not in IDLE.
- `Fault` out 1: sticky; set when the watchdog fires.

## Operation
- Storage: target[0..3] and current[0..3], 21 bits each.
- Target write: `TargetDuty` is clamped to [`DUTY_MIN`, `DUTY_MAX`] before storing. A write takes effect the next time that servo enters LOAD.
- State IDLE: `Busy`=0, outputs hold their values. `Enable`=1 moves the block to LOAD on the next cycle.
- State LOAD: one cycle. current[ServoNum] <= slew(current, target). `ActiveServoDuty` <= the same new value. The watchdog counter clears. Next state is WAIT.
- Slew: if target > current, add min(`STEP`, target−current). If target < current, subtract min(`STEP`, current−target). Otherwise current is unchanged. The result never crosses the target.
- State WAIT: the counter increments each cycle. The block advances on `ActivePeriodFinished`=1 or when the counter reaches `TIMEOUT`−1.
- Advance: `ServoNum` <= `ServoNum`+1, wrapping 3→0. On a timeout advance, `Fault` <= 1. Next state is LOAD if `Enable`=1, else IDLE.
- `ActivePeriodFinished` is sampled only in WAIT; a pulse in IDLE or LOAD is ignored.
- Pulse and timeout in the same cycle: treated as a normal finish, so `Fault` is not set.
- `Fault` set and `FaultClear` in the same cycle: set wins.
- `Enable` dropping mid-WAIT: the current period completes and the block advances, then goes to IDLE.

## Timing
- Reset values: `ServoNum`=0, `ActiveServoDuty`=`DUTY_CENTER`, all target/current=`DUTY_CENTER`, `Busy`=0, `Fault`=0, state IDLE, counter 0.
- `reset` mid-operation returns the block to the reset values on the next edge, discarding targets.
- `Enable` rising in IDLE: LOAD at cycle N+1, and the new `ActiveServoDuty` is visible at N+2.
- Pulse in WAIT at cycle N: `ServoNum` updates at N+1 (in LOAD), and the new duty is visible at N+2.
- Write at cycle N and LOAD of the same servo at cycle N: LOAD uses the old target, and the new target applies on the next visit.
- All outputs are registered, with no combinational input-to-output paths.

## Configuration
- `SERVO_SLEW_EN` defined: slew limiting by `STEP` as described.
- `SERVO_SLEW_EN` undefined: LOAD sets current = target directly. `STEP` is unused, and all other behaviour is identical.

## Test plan
- Reset, then `Enable`=1 with no writes → `ServoNum` 0,1,2,3,0 on successive pulses; `ActiveServoDuty` stays 150000; `Fault`=0.
- Write target[1]=180000 with slew enabled, then pulse each WAIT → servo 1 duty reads 151000, 152000, … on each visit, saturating at exactly 180000 after 30 visits.
- Write `TargetDuty`=50000 to servo 2 and 250000 to servo 3 → stored targets are 100000 and 200000; duties converge to those values and never go outside them.
- Hold `ActivePeriodFinished`=0 → advance at 2100000 cycles after LOAD with `Fault`=1. Assert `FaultClear` → `Fault`=0. Then pulse and timeout in the same cycle → `Fault` stays 0.
- Drop `Enable` mid-WAIT on servo 2, then pulse → `ServoNum`=3, state IDLE, `Busy`=0; `ActiveServoDuty` holds the servo 2 value.
- Assert `reset` during WAIT after targets were written → all outputs return to reset values next cycle; a subsequent run shows 150000 for all servos.
